fml_stream_writer: RTL and testbench

FML_STREAM_WRITER -- requirements
Module: fml_stream_writer

---
 rtl/fml_stream_writer.sv | 145 ++++++++++++++
 tb/tb_fml_stream_writer.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fml_stream_writer.sv
// fml_stream_writer
//   Collects 64-bit stream words into a four-word buffer and writes each full
//   (or flushed partial) buffer to FML memory as one four-beat write burst.
//   Consecutive bursts go to consecutive 32-byte blocks, starting at base_adr.
//
// Ports
//   sys_clk      : clock, all logic on its rising edge
//   sys_rst      : synchronous reset, active low
//   enable       : 1 = run, 0 = stop at the next burst boundary
//   base_adr     : first burst byte address (bits [4:0] ignored)
//   s_di/s_stb   : stream word and its valid
//   s_ack        : stream word accepted this cycle
//   flush        : pulse, writes out a partially filled buffer
//   busy         : block is not idle
//   burst_count  : bursts completed since the run started
//   fml_*        : FML master write port
//
// state | meaning
// IDLE  | waiting for enable
// FILL  | accepting stream words into the buffer
// REQ   | burst request on fml_stb, waiting for fml_eack
// DELAY | waiting out the data delay after fml_eack
// BEAT  | driving the four write beats
module fml_stream_writer #(
    parameter int unsigned adr_width  = 15,
    parameter logic [2:0]  data_delay = 3'd2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 enable,
    input  logic [adr_width-1:0] base_adr,
    input  logic [63:0]          s_di,
    input  logic                 s_stb,
    output logic                 s_ack,
    input  logic                 flush,
    output logic                 busy,
    output logic [15:0]          burst_count,
    output logic [adr_width-1:0] fml_adr,
    output logic                 fml_stb,
    output logic                 fml_we,
    input  logic                 fml_eack,
    output logic [7:0]           fml_sel,
    output logic [63:0]          fml_do
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        REQ,
        DELAY,
        BEAT
    } state_t;

    state_t               state;
    logic [adr_width-1:0] burst_adr;
    logic [1:0]           fill_cnt;
    logic [63:0]          buffer [4];
    logic [2:0]           dly_cnt;
    logic [1:0]           beat;

    logic fill_ack;
    logic fill_full;
    logic fill_flush;
    logic unused_base_bits;

    // The low address bits never reach the burst address.
    assign unused_base_bits = ^base_adr[4:0];

    assign fill_ack   = (state == FILL) && s_stb;
    assign fill_full  = fill_ack && (fill_cnt == 2'd3);
    // A word accepted in the flush cycle itself makes the buffer non-empty.
    assign fill_flush = flush && (fill_ack || (fill_cnt != 2'd0));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state       <= IDLE;
            burst_adr   <= '0;
            burst_count <= '0;
            fill_cnt    <= '0;
            dly_cnt     <= '0;
            beat        <= '0;
            for (int i = 0; i < 4; i++) buffer[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        burst_adr   <= {base_adr[adr_width-1:5], 5'b0};
                        burst_count <= '0;
                        state       <= FILL;
                    end
                end
                FILL: begin
                    if (fill_ack) begin
                        buffer[fill_cnt] <= s_di;
                        fill_cnt         <= fill_cnt + 2'd1;
                    end
                    if (fill_full || fill_flush) begin
                        state <= REQ;
                    end else if (!enable && (fill_cnt == 2'd0) && !fill_ack) begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (fml_eack) begin
                        beat <= '0;
                        // dly_cnt counts the DELAY cycles still to come after this one.
                        if (data_delay <= 3'd1) begin
                            state <= BEAT;
                        end else begin
                            dly_cnt <= data_delay - 3'd2;
                            state   <= DELAY;
                        end
                    end
                end
                DELAY: begin
                    if (dly_cnt == 3'd0) begin
                        state <= BEAT;
                    end else begin
                        dly_cnt <= dly_cnt - 3'd1;
                    end
                end
                BEAT: begin
                    beat <= beat + 2'd1;
                    if (beat == 2'd3) begin
                        burst_adr   <= burst_adr + adr_width'(32);
                        burst_count <= burst_count + 16'd1;
                        fill_cnt    <= '0;
                        for (int i = 0; i < 4; i++) buffer[i] <= '0;
                        state       <= FILL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_ack   = fill_ack;
    assign busy    = (state != IDLE);
    assign fml_adr = burst_adr;
    assign fml_stb = (state == REQ);
    assign fml_we  = (state == REQ);
    assign fml_sel = {8{state == REQ}};
    assign fml_do  = (state == BEAT) ? buffer[beat] : 64'h0;

endmodule

// File: tb/tb_fml_stream_writer.sv
// tb_fml_stream_writer
//   Drives random stream traffic into fml_stream_writer, acts as the FML
//   slave (acknowledging requests after a programmable latency and capturing
//   the beats at their expected cycles), and compares the captured bursts
//   against a queue-based model of the buffering rules.
//
// Ports: none (top-level bench).
module tb_fml_stream_writer;

    localparam int AW = 15;
    localparam int DD = 2;

    logic          sys_clk   = 1'b0;
    logic          sys_rst   = 1'b0;
    logic          enable    = 1'b0;
    logic [AW-1:0] base_adr  = '0;
    logic [63:0]   s_di      = '0;
    logic          s_stb     = 1'b0;
    logic          flush     = 1'b0;
    logic          fml_eack  = 1'b0;
    logic          s_ack;
    logic          busy;
    logic [15:0]   burst_count;
    logic [AW-1:0] fml_adr;
    logic          fml_stb;
    logic          fml_we;
    logic [7:0]    fml_sel;
    logic [63:0]   fml_do;

    fml_stream_writer #(
        .adr_width (AW),
        .data_delay(3'(DD))
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .enable     (enable),
        .base_adr   (base_adr),
        .s_di       (s_di),
        .s_stb      (s_stb),
        .s_ack      (s_ack),
        .flush      (flush),
        .busy       (busy),
        .burst_count(burst_count),
        .fml_adr    (fml_adr),
        .fml_stb    (fml_stb),
        .fml_we     (fml_we),
        .fml_eack   (fml_eack),
        .fml_sel    (fml_sel),
        .fml_do     (fml_do)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: words accepted so far, grouped into bursts
    logic [AW-1:0] exp_adr_q [$];
    logic [63:0]   exp_word_q[$];
    logic [63:0]   part_q    [$];
    logic [AW-1:0] model_adr;
    int            model_count;

    // what the slave actually saw
    logic [AW-1:0] got_adr_q [$];
    logic [63:0]   got_word_q[$];
    logic [63:0]   mem [int];
    int stray_do = 0;
    int stb_bad  = 0;
    int ack_bad  = 0;
    int ctl_bad  = 0;
    int eack_lat = 0;
    bit eack_rand = 1'b0;
    bit mon_in_burst = 1'b0;
    int mon_rel = -1;

    task automatic model_close();
        if (part_q.size() == 0) return;
        while (part_q.size() < 4) part_q.push_back(64'h0);
        exp_adr_q.push_back(model_adr);
        foreach (part_q[i]) exp_word_q.push_back(part_q[i]);
        part_q.delete();
        model_adr = model_adr + AW'(32);
        model_count++;
    endtask

    task automatic model_word(input logic [63:0] w);
        part_q.push_back(w);
        if (part_q.size() == 4) model_close();
    endtask

    // FML slave: acknowledges requests and captures beats at E+DD+k
    initial begin : slave
        int cyc;
        int e_cyc;
        int wait_n;
        int lat;
        logic [63:0]   cur [4];
        logic [AW-1:0] cur_adr;
        cyc = 0; e_cyc = 0; wait_n = 0; lat = 0; cur_adr = '0;
        forever begin
            @(negedge sys_clk);
            #2;
            cyc++;
            fml_eack = 1'b0;
            if (!sys_rst) begin
                mon_in_burst = 1'b0;
                wait_n = 0;
            end else begin
                if ((fml_stb || mon_in_burst) && s_ack) ack_bad++;
                if (fml_stb) begin
                    if (fml_we !== 1'b1 || fml_sel !== 8'hFF) ctl_bad++;
                end else begin
                    if (fml_we !== 1'b0 || fml_sel !== 8'h00) ctl_bad++;
                end
                if (mon_in_burst) begin
                    int rel;
                    rel = cyc - e_cyc;
                    if (fml_stb) stb_bad++;
                    if (rel >= DD && rel < DD + 4) cur[rel-DD] = fml_do;
                    else if (fml_do !== 64'h0) stray_do++;
                    if (rel == DD + 3) begin
                        got_adr_q.push_back(cur_adr);
                        for (int k = 0; k < 4; k++) begin
                            got_word_q.push_back(cur[k]);
                            mem[int'(cur_adr + AW'(8 * k))] = cur[k];
                        end
                        mon_in_burst = 1'b0;
                    end
                end else if (fml_do !== 64'h0) begin
                    stray_do++;
                end
                if (!mon_in_burst && fml_stb) begin
                    if (wait_n == 0) begin
                        cur_adr = fml_adr;
                        lat = eack_rand ? int'($urandom_range(0, 3)) : eack_lat;
                    end else if (fml_adr !== cur_adr) begin
                        stb_bad++;
                    end
                    if (wait_n == lat) begin
                        fml_eack = 1'b1;
                        mon_in_burst = 1'b1;
                        e_cyc = cyc;
                        wait_n = 0;
                    end else begin
                        wait_n++;
                    end
                end
            end
            mon_rel = mon_in_burst ? (cyc - e_cyc) : -1;
        end
    end

    task automatic drive_cycle(input bit stb, input logic [63:0] di, input bit fl, output bit acked);
        @(negedge sys_clk);
        s_stb = stb;
        s_di  = di;
        flush = fl;
        #1;
        acked = s_ack;
        if (acked) model_word(di);
        if (fl) model_close();
    endtask

    task automatic send_word(input logic [63:0] w, input int gap);
        bit a;
        int n;
        repeat (gap) drive_cycle(1'b0, 64'h0, 1'b0, a);
        a = 1'b0;
        n = 0;
        while (!a && n < 300) begin
            drive_cycle(1'b1, w, 1'b0, a);
            n++;
        end
        if (!a) begin
            n_cmp++; n_bad++;
            $display("FAIL send_word: no s_ack within %0d cycles, required 1", n);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (got_adr_q.size() < exp_adr_q.size() && n < 300) begin
            @(negedge sys_clk);
            #3;
            n++;
        end
        if (got_adr_q.size() < exp_adr_q.size()) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_drain: bursts seen %0d, required %0d", got_adr_q.size(), exp_adr_q.size());
        end
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        sys_rst = 1'b0; enable = 1'b0; s_stb = 1'b0; flush = 1'b0;
        repeat (2) @(negedge sys_clk);
        exp_adr_q.delete(); exp_word_q.delete(); part_q.delete();
        got_adr_q.delete(); got_word_q.delete(); mem.delete();
        sys_rst = 1'b1;
    endtask

    task automatic start_run(input logic [AW-1:0] base);
        base_adr    = base;
        enable      = 1'b1;
        model_adr   = {base[AW-1:5], 5'b0};
        model_count = 0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b0; enable = 1'b1; base_adr = 15'h7FFF;
        s_stb = 1'b1; flush = 1'b1; s_di = '1;
        repeat (3) @(negedge sys_clk);
        #1;
        n_cmp++; if (s_ack !== 1'b0) begin n_bad++; $display("FAIL rst_s_ack: got %b want 0", s_ack); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (fml_stb !== 1'b0) begin n_bad++; $display("FAIL rst_fml_stb: got %b want 0", fml_stb); end
        n_cmp++; if (fml_we !== 1'b0) begin n_bad++; $display("FAIL rst_fml_we: got %b want 0", fml_we); end
        n_cmp++; if (fml_sel !== 8'h00) begin n_bad++; $display("FAIL rst_fml_sel: got %h want 00", fml_sel); end
        n_cmp++; if (fml_do !== 64'h0) begin n_bad++; $display("FAIL rst_fml_do: got %h want 0", fml_do); end
        n_cmp++; if (fml_adr !== '0) begin n_bad++; $display("FAIL rst_fml_adr: got %h want 0", fml_adr); end
        n_cmp++; if (burst_count !== 16'h0) begin n_bad++; $display("FAIL rst_burst_count: got %0d want 0", burst_count); end
        @(negedge sys_clk);
        enable = 1'b0; flush = 1'b0; sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        #1;
        n_cmp++; if (s_ack !== 1'b0) begin n_bad++; $display("FAIL idle_s_ack: got %b want 0", s_ack); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
        n_cmp++; if (fml_adr !== '0) begin n_bad++; $display("FAIL idle_fml_adr: got %h want 0", fml_adr); end
        s_stb = 1'b0;
    endtask

    task automatic test_single_burst();
        bit a;
        apply_reset();
        start_run(15'h0040);
        eack_rand = 1'b0; eack_lat = 2;
        for (int i = 1; i <= 4; i++) send_word(64'(i), 0);
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        wait_drain();
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        n_cmp++;
        if (got_adr_q.size() != 1) begin
            n_bad++; $display("FAIL single_nbursts: got %0d want 1", got_adr_q.size());
        end else begin
            n_cmp++; if (got_adr_q[0] !== 15'h0040) begin n_bad++; $display("FAIL single_adr: got %h want 0040", got_adr_q[0]); end
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (got_word_q[k] !== 64'(k + 1)) begin
                    n_bad++; $display("FAIL single_beat%0d: got %h want %h", k, got_word_q[k], 64'(k + 1));
                end
            end
        end
        n_cmp++; if (burst_count !== 16'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", burst_count); end
    endtask

    task automatic test_stream_8();
        bit a;
        logic [63:0] w [8];
        apply_reset();
        start_run(15'h0040);
        eack_rand = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w[i] = {$urandom, $urandom};
            send_word(w[i], int'($urandom_range(0, 2)));
        end
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        wait_drain();
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (!mem.exists(32'h40 + 8 * i)) begin
                n_bad++; $display("FAIL stream8_mem: address %h never written", 32'h40 + 8 * i);
            end else if (mem[32'h40 + 8 * i] !== w[i]) begin
                n_bad++; $display("FAIL stream8_mem: at %h got %h want %h", 32'h40 + 8 * i, mem[32'h40 + 8 * i], w[i]);
            end
        end
        n_cmp++; if (burst_count !== 16'd2) begin n_bad++; $display("FAIL stream8_count: got %0d want 2", burst_count); end
    endtask

    task automatic test_flush();
        bit a;
        logic [63:0] wa, wb, wc;
        apply_reset();
        start_run(15'h0200);
        eack_rand = 1'b1;
        wa = {$urandom, $urandom} | 64'h1;
        wb = {$urandom, $urandom} | 64'h1;
        wc = {$urandom, $urandom} | 64'h1;
        send_word(wa, 0);
        send_word(wb, 1);
        drive_cycle(1'b0, 64'h0, 1'b1, a);
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        wait_drain();
        n_cmp++;
        if (got_word_q.size() != 4) begin
            n_bad++; $display("FAIL flush_partial_size: got %0d words want 4", got_word_q.size());
        end else begin
            n_cmp++; if (got_word_q[0] !== wa) begin n_bad++; $display("FAIL flush_w0: got %h want %h", got_word_q[0], wa); end
            n_cmp++; if (got_word_q[1] !== wb) begin n_bad++; $display("FAIL flush_w1: got %h want %h", got_word_q[1], wb); end
            n_cmp++; if (got_word_q[2] !== 64'h0) begin n_bad++; $display("FAIL flush_w2: got %h want 0", got_word_q[2]); end
            n_cmp++; if (got_word_q[3] !== 64'h0) begin n_bad++; $display("FAIL flush_w3: got %h want 0", got_word_q[3]); end
        end
        // flush with an empty buffer must not start a burst
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        drive_cycle(1'b0, 64'h0, 1'b1, a);
        repeat (12) drive_cycle(1'b0, 64'h0, 1'b0, a);
        n_cmp++; if (got_adr_q.size() != 1) begin n_bad++; $display("FAIL flush_empty: got %0d bursts want 1", got_adr_q.size()); end
        // word and flush in the same cycle
        drive_cycle(1'b1, wc, 1'b1, a);
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        wait_drain();
        n_cmp++;
        if (got_adr_q.size() != exp_adr_q.size() || got_word_q.size() != exp_word_q.size()) begin
            n_bad++; $display("FAIL flush_nbursts: got %0d want %0d", got_adr_q.size(), exp_adr_q.size());
        end else begin
            foreach (exp_adr_q[i]) begin
                n_cmp++; if (got_adr_q[i] !== exp_adr_q[i]) begin n_bad++; $display("FAIL flush_adr%0d: got %h want %h", i, got_adr_q[i], exp_adr_q[i]); end
            end
            foreach (exp_word_q[i]) begin
                n_cmp++; if (got_word_q[i] !== exp_word_q[i]) begin n_bad++; $display("FAIL flush_word%0d: got %h want %h", i, got_word_q[i], exp_word_q[i]); end
            end
        end
    endtask

    task automatic test_wrap();
        bit a;
        apply_reset();
        start_run(15'h7FF3);
        eack_rand = 1'b1;
        for (int i = 0; i < 8; i++) send_word({$urandom, $urandom}, int'($urandom_range(0, 1)));
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        wait_drain();
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        n_cmp++;
        if (got_adr_q.size() != 2) begin
            n_bad++; $display("FAIL wrap_nbursts: got %0d want 2", got_adr_q.size());
        end else begin
            n_cmp++; if (got_adr_q[0] !== 15'h7FE0) begin n_bad++; $display("FAIL wrap_adr0: got %h want 7fe0", got_adr_q[0]); end
            n_cmp++; if (got_adr_q[1] !== 15'h0000) begin n_bad++; $display("FAIL wrap_adr1: got %h want 0000", got_adr_q[1]); end
        end
        n_cmp++; if (burst_count !== 16'd2) begin n_bad++; $display("FAIL wrap_count: got %0d want 2", burst_count); end
    endtask

    task automatic test_enable_drop();
        bit a;
        bit done;
        int n;
        logic [63:0] wa, wb;
        apply_reset();
        start_run(15'h0300);
        eack_rand = 1'b1;
        for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, 0);
        enable = 1'b0;
        base_adr = 15'h1240;
        done = 1'b0;
        n = 0;
        // stream stays valid through REQ/DELAY/BEAT and must not be accepted
        while (!done && n < 100) begin
            drive_cycle(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, a);
            n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL enable_s_ack_burst: got %b want 0", a); end
            #2;
            if (got_adr_q.size() == 1) done = 1'b1;
            n++;
        end
        if (!done) begin n_cmp++; n_bad++; $display("FAIL enable_burst_timeout: got no burst want 1"); end
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL enable_busy_fill: got %b want 1", busy); end
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL enable_busy_idle: got %b want 0", busy); end
        n_cmp++;
        if (got_adr_q.size() != 1 || got_word_q.size() != 4 || exp_word_q.size() != 4) begin
            n_bad++; $display("FAIL enable_nbursts: got %0d want 1", got_adr_q.size());
        end else begin
            n_cmp++; if (got_adr_q[0] !== 15'h0300) begin n_bad++; $display("FAIL enable_adr: got %h want 0300", got_adr_q[0]); end
            foreach (exp_word_q[i]) begin
                n_cmp++; if (got_word_q[i] !== exp_word_q[i]) begin n_bad++; $display("FAIL enable_word%0d: got %h want %h", i, got_word_q[i], exp_word_q[i]); end
            end
        end
        // a partial buffer is held with enable low until flushed
        apply_reset();
        start_run(15'h0400);
        wa = {$urandom, $urandom};
        wb = {$urandom, $urandom};
        send_word(wa, 0);
        send_word(wb, 0);
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        enable = 1'b0;
        repeat (6) drive_cycle(1'b0, 64'h0, 1'b0, a);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hold_busy: got %b want 1", busy); end
        drive_cycle(1'b0, 64'h0, 1'b1, a);
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        wait_drain();
        n_cmp++;
        if (got_word_q.size() != 4) begin
            n_bad++; $display("FAIL hold_nwords: got %0d want 4", got_word_q.size());
        end else begin
            n_cmp++; if (got_adr_q[0] !== 15'h0400) begin n_bad++; $display("FAIL hold_adr: got %h want 0400", got_adr_q[0]); end
            n_cmp++; if (got_word_q[1] !== wb) begin n_bad++; $display("FAIL hold_w1: got %h want %h", got_word_q[1], wb); end
            n_cmp++; if (got_word_q[3] !== 64'h0) begin n_bad++; $display("FAIL hold_w3: got %h want 0", got_word_q[3]); end
        end
        repeat (3) drive_cycle(1'b0, 64'h0, 1'b0, a);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hold_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_reset_abort();
        bit a;
        int n;
        apply_reset();
        start_run(15'h0100);
        eack_rand = 1'b0; eack_lat = 0;
        for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, 0);
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        wait_drain();
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        n_cmp++; if (burst_count !== 16'd1) begin n_bad++; $display("FAIL abort_count_before: got %0d want 1", burst_count); end
        for (int i = 0; i < 4; i++) send_word({$urandom, $urandom} | 64'h1, 0);
        n = 0;
        do begin
            drive_cycle(1'b0, 64'h0, 1'b0, a);
            #2;
            n++;
        end while (!(mon_in_burst && mon_rel == 1) && n < 50);
        if (n >= 50) begin n_cmp++; n_bad++; $display("FAIL abort_no_delay: got no DELAY cycle want one"); end
        sys_rst = 1'b0;
        enable = 1'b0;
        @(negedge sys_clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (fml_stb !== 1'b0) begin n_bad++; $display("FAIL abort_fml_stb: got %b want 0", fml_stb); end
        n_cmp++; if (fml_do !== 64'h0) begin n_bad++; $display("FAIL abort_fml_do: got %h want 0", fml_do); end
        n_cmp++; if (burst_count !== 16'd0) begin n_bad++; $display("FAIL abort_count: got %0d want 0", burst_count); end
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (10) drive_cycle(1'b0, 64'h0, 1'b0, a);
        n_cmp++; if (got_adr_q.size() != 1) begin n_bad++; $display("FAIL abort_no_more_bursts: got %0d want 1", got_adr_q.size()); end
    endtask

    task automatic test_random();
        bit a;
        int nw;
        apply_reset();
        start_run(AW'($urandom));
        eack_rand = 1'b1;
        for (int r = 0; r < 4; r++) begin
            nw = int'($urandom_range(1, 11));
            for (int i = 0; i < nw; i++) send_word({$urandom, $urandom}, int'($urandom_range(0, 3)));
            drive_cycle(1'b0, 64'h0, 1'b0, a);
            wait_drain();
            drive_cycle(1'b0, 64'h0, 1'b1, a);
            drive_cycle(1'b0, 64'h0, 1'b0, a);
            wait_drain();
        end
        drive_cycle(1'b0, 64'h0, 1'b0, a);
        n_cmp++;
        if (got_adr_q.size() != exp_adr_q.size() || got_word_q.size() != exp_word_q.size()) begin
            n_bad++; $display("FAIL random_nbursts: got %0d want %0d", got_adr_q.size(), exp_adr_q.size());
        end else begin
            foreach (exp_adr_q[i]) begin
                n_cmp++; if (got_adr_q[i] !== exp_adr_q[i]) begin n_bad++; $display("FAIL random_adr%0d: got %h want %h", i, got_adr_q[i], exp_adr_q[i]); end
            end
            foreach (exp_word_q[i]) begin
                n_cmp++; if (got_word_q[i] !== exp_word_q[i]) begin n_bad++; $display("FAIL random_word%0d: got %h want %h", i, got_word_q[i], exp_word_q[i]); end
            end
        end
        n_cmp++; if (burst_count !== 16'(model_count)) begin n_bad++; $display("FAIL random_count: got %0d want %0d", burst_count, model_count); end
    endtask

    task automatic test_protocol();
        n_cmp++; if (stray_do != 0) begin n_bad++; $display("FAIL proto_fml_do_outside_beats: got %0d cycles want 0", stray_do); end
        n_cmp++; if (stb_bad != 0) begin n_bad++; $display("FAIL proto_fml_stb: got %0d violations want 0", stb_bad); end
        n_cmp++; if (ack_bad != 0) begin n_bad++; $display("FAIL proto_s_ack_outside_fill: got %0d cycles want 0", ack_bad); end
        n_cmp++; if (ctl_bad != 0) begin n_bad++; $display("FAIL proto_we_sel: got %0d cycles want 0", ctl_bad); end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_single_burst();
        test_stream_8();
        test_flush();
        test_wrap();
        test_enable_drop();
        test_reset_abort();
        test_random();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
